// File: rtl/ram_bank.sv
// ram_bank: single-clock data RAM with byte-strobe writes and wait-state registered reads.
// Define RAM_FWD_EN to forward a same-edge write into the word sampled for a read response.
module ram_bank #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 20,
    parameter int unsigned DEPTH  = 1024,
    parameter int unsigned RD_LAT = 1
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                wr_en_i,
    input  logic [ADDR_W-1:0]   wr_addr_i,
    input  logic [DATA_W-1:0]   wr_data_i,
    input  logic [DATA_W/8-1:0] wr_be_i,
    input  logic                rd_req_i,
    input  logic [ADDR_W-1:0]   rd_addr_i,
    output logic                rd_ready_o,
    output logic                rd_valid_o,
    output logic [DATA_W-1:0]   rd_data_o,
    output logic                rd_err_o
);

    localparam int              NB        = DATA_W / 8;
    localparam int unsigned     IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] DEPTH_A   = (ADDR_W + 1)'(DEPTH);
    localparam logic [2:0]      WAIT_INIT = (RD_LAT > 1) ? 3'(RD_LAT - 2) : 3'd0;

    typedef enum logic [1:0] {StIdle, StWait, StResp} state_t;

    state_t              state_q, state_d;
    logic [2:0]          cnt_q, cnt_d;
    logic [ADDR_W-1:0]   addr_q;
    logic                accept;
    logic                wr_ok;
    logic                samp_ok;
    logic [ADDR_W-1:0]   samp_addr;
    logic [DATA_W-1:0]   samp_word;
    logic [DATA_W-1:0]   mem [DEPTH];

    assign rd_ready_o = (state_q != StWait);
    assign rd_valid_o = (state_q == StResp);
    assign accept     = rd_req_i & rd_ready_o;
    assign wr_ok      = wr_en_i & ({1'b0, wr_addr_i} < DEPTH_A);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle, StResp: begin
                if (accept) begin
                    if (RD_LAT == 1) begin
                        state_d = StResp;
                    end else begin
                        state_d = StWait;
                        cnt_d   = WAIT_INIT;
                    end
                end else begin
                    state_d = StIdle;
                end
            end
            StWait: begin
                if (cnt_q == 3'd0) begin
                    state_d = StResp;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Entering RESP from WAIT uses the latched address; a zero-wait accept uses the live one.
    always_comb begin
        samp_addr = (state_q == StWait) ? addr_q : rd_addr_i;
        samp_ok   = ({1'b0, samp_addr} < DEPTH_A);
        samp_word = samp_ok ? mem[samp_addr[IDX_W-1:0]] : '0;
`ifdef RAM_FWD_EN
        if (samp_ok && wr_ok && (wr_addr_i == samp_addr)) begin
            for (int k = 0; k < NB; k++) begin
                if (wr_be_i[k]) begin
                    samp_word[8*k +: 8] = wr_data_i[8*k +: 8];
                end
            end
        end
`endif
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= StIdle;
            cnt_q     <= 3'd0;
            addr_q    <= '0;
            rd_data_o <= '0;
            rd_err_o  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                addr_q <= rd_addr_i;
            end
            if (state_d == StResp) begin
                rd_data_o <= samp_word;
                rd_err_o  <= !samp_ok;
            end
        end
    end

    // Array is deliberately not reset.
    always_ff @(posedge clk_i) begin
        if (!rst_i && wr_ok) begin
            for (int k = 0; k < NB; k++) begin
                if (wr_be_i[k]) begin
                    mem[wr_addr_i[IDX_W-1:0]][8*k +: 8] <= wr_data_i[8*k +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_ram_bank.sv
// Bench for ram_bank: three latencies (1, 3, 4) share one stimulus stream and are checked
// every cycle against an event-level reference model, plus directed literal checks.
module tb_ram_bank;

    localparam int AW    = 20;
    localparam int DEPTH = 1024;

    logic          clk     = 1'b0;
    logic          rst     = 1'b1;
    logic          wr_en   = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [31:0]   wr_data = '0;
    logic [3:0]    wr_be   = '0;
    logic          rd_req  = 1'b0;
    logic [AW-1:0] rd_addr = '0;

    logic [2:0]    ready, valid, err;
    logic [31:0]   data [3];

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    ram_bank #(.DATA_W(32), .ADDR_W(AW), .DEPTH(DEPTH), .RD_LAT(1)) u_lat1 (
        .clk_i(clk), .rst_i(rst), .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
        .wr_be_i(wr_be), .rd_req_i(rd_req), .rd_addr_i(rd_addr), .rd_ready_o(ready[0]),
        .rd_valid_o(valid[0]), .rd_data_o(data[0]), .rd_err_o(err[0])
    );
    ram_bank #(.DATA_W(32), .ADDR_W(AW), .DEPTH(DEPTH), .RD_LAT(3)) u_lat3 (
        .clk_i(clk), .rst_i(rst), .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
        .wr_be_i(wr_be), .rd_req_i(rd_req), .rd_addr_i(rd_addr), .rd_ready_o(ready[1]),
        .rd_valid_o(valid[1]), .rd_data_o(data[1]), .rd_err_o(err[1])
    );
    ram_bank #(.DATA_W(32), .ADDR_W(AW), .DEPTH(DEPTH), .RD_LAT(4)) u_lat4 (
        .clk_i(clk), .rst_i(rst), .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
        .wr_be_i(wr_be), .rd_req_i(rd_req), .rd_addr_i(rd_addr), .rd_ready_o(ready[2]),
        .rd_valid_o(valid[2]), .rd_data_o(data[2]), .rd_err_o(err[2])
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic int lat_of(input int j);
        return (j == 0) ? 1 : ((j == 1) ? 3 : 4);
    endfunction

    // Reference model: memory image plus, per instance, the outstanding read and the
    // number of edges left until its response is sampled.
    logic [31:0]   mem_m [DEPTH];
    bit            live = 1'b0;
    bit   [2:0]    m_ready, m_valid, m_err, pend;
    logic [31:0]   m_data [3];
    int            remain [3];
    logic [AW-1:0] paddr [3];

    function automatic logic [31:0] sample(input logic [AW-1:0] a);
        logic [31:0] w;
        if (int'(a) >= DEPTH) return 32'h0;
        w = mem_m[a[9:0]];
`ifdef RAM_FWD_EN
        if (wr_en && (wr_addr == a)) begin
            for (int k = 0; k < 4; k++) begin
                if (wr_be[k]) w[8*k +: 8] = wr_data[8*k +: 8];
            end
        end
`endif
        return w;
    endfunction

    initial begin
        for (int i = 0; i < DEPTH; i++) mem_m[i] = 32'h0;
        forever begin
            @(posedge clk);
            if (rst) begin
                live = 1'b1;
                for (int j = 0; j < 3; j++) begin
                    pend[j] = 1'b0; m_valid[j] = 1'b0; m_err[j] = 1'b0;
                    m_ready[j] = 1'b1; m_data[j] = 32'h0;
                end
            end else if (live) begin
                for (int j = 0; j < 3; j++) begin
                    bit acc;
                    bit nv;
                    acc = rd_req && m_ready[j];
                    nv  = 1'b0;
                    if (pend[j]) begin
                        remain[j]--;
                        if (remain[j] == 0) begin
                            m_data[j] = sample(paddr[j]);
                            m_err[j]  = (int'(paddr[j]) >= DEPTH);
                            pend[j]   = 1'b0;
                            nv        = 1'b1;
                        end
                    end
                    if (acc) begin
                        paddr[j]  = rd_addr;
                        remain[j] = lat_of(j) - 1;
                        if (remain[j] == 0) begin
                            m_data[j] = sample(rd_addr);
                            m_err[j]  = (int'(rd_addr) >= DEPTH);
                            nv        = 1'b1;
                        end else begin
                            pend[j] = 1'b1;
                        end
                    end
                    m_valid[j] = nv;
                    m_ready[j] = !pend[j];
                end
                if (wr_en && (int'(wr_addr) < DEPTH)) begin
                    for (int k = 0; k < 4; k++) begin
                        if (wr_be[k]) mem_m[wr_addr[9:0]][8*k +: 8] = wr_data[8*k +: 8];
                    end
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (live) begin
                for (int j = 0; j < 3; j++) begin
                    check($sformatf("lat%0d ready", lat_of(j)), 32'(ready[j]), 32'(m_ready[j]));
                    check($sformatf("lat%0d valid", lat_of(j)), 32'(valid[j]), 32'(m_valid[j]));
                    check($sformatf("lat%0d data", lat_of(j)), data[j], m_data[j]);
                    if (m_valid[j]) begin
                        check($sformatf("lat%0d err", lat_of(j)), 32'(err[j]), 32'(m_err[j]));
                    end
                end
            end
        end
    end

    task automatic set_wr(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] be);
        wr_en = 1'b1; wr_addr = a; wr_data = d; wr_be = be; rd_req = 1'b0;
    endtask

    task automatic set_rd(input logic [AW-1:0] a);
        wr_en = 1'b0; rd_req = 1'b1; rd_addr = a;
    endtask

    task automatic set_idle();
        wr_en = 1'b0; rd_req = 1'b0;
    endtask

    task automatic nop(input int n);
        repeat (n) begin
            @(negedge clk);
            set_idle();
        end
    endtask

    function automatic logic [AW-1:0] pick_addr();
        int r;
        r = int'($urandom_range(0, 9));
        if (r < 6) return AW'($urandom_range(0, 15));
        if (r < 8) return AW'($urandom_range(1020, 1023));
        if (r < 9) return AW'($urandom_range(1024, 1027));
        return AW'(32'hFFFF0 + $urandom_range(0, 15));
    endfunction

    logic [31:0] coll_exp;

    initial begin
`ifdef RAM_FWD_EN
        coll_exp = 32'h0000_5678;
`else
        coll_exp = 32'h0000_0000;
`endif
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("reset ready", 32'(ready[0]), 32'd1);
        check("reset valid", 32'(valid[2]), 32'd0);
        check("reset data", data[1], 32'h0);
        for (int a = 0; a < 16; a++) begin
            @(negedge clk); set_wr(AW'(a), 32'h0, 4'hF);
        end
        for (int a = 1020; a < 1024; a++) begin
            @(negedge clk); set_wr(AW'(a), 32'h0, 4'hF);
        end

        // Byte-strobe merge.
        @(negedge clk); set_wr(20'd5, 32'hAABB_CCDD, 4'hF);
        @(negedge clk); set_wr(20'd5, 32'h1122_3344, 4'b0101);
        @(negedge clk); set_rd(20'd5);
        @(negedge clk); set_idle();
        check("strobe valid", 32'(valid[0]), 32'd1);
        check("strobe data", data[0], 32'hAA22_CC44);
        check("strobe err", 32'(err[0]), 32'd0);
        nop(6);

        // Wait states on the latency-4 instance with the request held.
        @(negedge clk); set_wr(20'd3, 32'hCAFE_0003, 4'hF);
        @(negedge clk); set_rd(20'd3);
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            check($sformatf("wait%0d ready", i), 32'(ready[2]), 32'd0);
            check($sformatf("wait%0d valid", i), 32'(valid[2]), 32'd0);
        end
        @(negedge clk);
        check("wait resp valid", 32'(valid[2]), 32'd1);
        check("wait resp data", data[2], 32'hCAFE_0003);
        set_idle();
        nop(6);

        // Back-to-back reads at latency 1.
        @(negedge clk); set_wr(20'd0, 32'h0000_0100, 4'hF);
        @(negedge clk); set_wr(20'd1, 32'h0000_0101, 4'hF);
        @(negedge clk); set_wr(20'd2, 32'h0000_0102, 4'hF);
        @(negedge clk); set_rd(20'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (i < 2) set_rd(AW'(i + 1)); else set_idle();
            check($sformatf("b2b%0d valid", i), 32'(valid[0]), 32'd1);
            check($sformatf("b2b%0d ready", i), 32'(ready[0]), 32'd1);
            check($sformatf("b2b%0d data", i), data[0], 32'h100 + 32'(i));
        end
        nop(6);

        // Out-of-range write is dropped and read is flagged.
        @(negedge clk); set_wr(20'd1024, 32'hDEAD_BEEF, 4'hF);
        @(negedge clk); set_rd(20'd1024);
        @(negedge clk); set_idle();
        check("oor data", data[0], 32'h0);
        check("oor err", 32'(err[0]), 32'd1);
        nop(6);
        @(negedge clk); set_rd(20'd0);
        @(negedge clk); set_idle();
        check("alias data", data[0], 32'h0000_0100);
        check("alias err", 32'(err[0]), 32'd0);
        nop(6);

        // Write and read of the same word on the sampling edge.
        @(negedge clk);
        set_wr(20'd7, 32'h1234_5678, 4'b0011);
        rd_req = 1'b1; rd_addr = 20'd7;
        @(negedge clk); set_idle();
        check("collision data", data[0], coll_exp);
        nop(6);
        @(negedge clk); set_rd(20'd7);
        @(negedge clk); set_idle();
        check("after collision", data[0], 32'h0000_5678);
        nop(6);

        // Reset one cycle after accept drops the latency-3 read.
        @(negedge clk); set_rd(20'd5);
        @(negedge clk); set_idle(); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        check("midrst ready", 32'(ready[1]), 32'd1);
        check("midrst valid", 32'(valid[1]), 32'd0);
        check("midrst data", data[1], 32'h0);
        repeat (4) begin
            @(negedge clk);
            check("midrst no pulse", 32'(valid[1]), 32'd0);
        end
        @(negedge clk); set_rd(20'd5);
        @(negedge clk); set_idle();
        @(negedge clk);
        @(negedge clk);
        check("postrst valid", 32'(valid[1]), 32'd1);
        check("postrst data", data[1], 32'hAA22_CC44);
        nop(4);

        repeat (3000) begin
            @(negedge clk);
            rst     = ($urandom_range(0, 99) == 0);
            wr_en   = ($urandom_range(0, 1) == 1);
            wr_addr = pick_addr();
            wr_data = $urandom;
            wr_be   = 4'($urandom_range(0, 15));
            rd_req  = ($urandom_range(0, 9) < 6);
            rd_addr = pick_addr();
        end
        @(negedge clk); rst = 1'b0; set_idle();
        nop(8);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ram_bank.md
Name: ram_bank

Overview:
Parametrised single-clock data RAM for the rv32imac core, succeeding the flat combinational-read RAM.
- Width and depth are generics.
- Writes use byte strobes.
- Reads are registered with a configurable wait-state latency and a request/valid handshake, so the LSU can model slow memory.
- Out-of-range addresses are flagged rather than aliased.

Parameters:
DATA_W, 32, data word width in bits; multiple of 8.
ADDR_W, 20, word-address width.
DEPTH, 1024, number of words implemented; must be <= 2**ADDR_W.
RD_LAT, 1, cycles from read accept to rd_valid_o; legal range 1..8.

Ports:
clk_i  in  1  clock; all state changes on rising edge.
rst_i  in  1  synchronous reset, active-high.
wr_en_i  in  1  write strobe; one write per cycle, no handshake.
wr_addr_i  in  ADDR_W  write word address.
wr_data_i  in  DATA_W  write data.
wr_be_i  in  DATA_W/8  byte enables; bit k gates byte k, i.e. bits [8k+7:8k].
rd_req_i  in  1  read request.
rd_addr_i  in  ADDR_W  read word address; sampled on accept.
rd_ready_o  out  1  high when a read request can be accepted this cycle.
rd_valid_o  out  1  one-cycle pulse; rd_data_o and rd_err_o are valid.
rd_data_o  out  DATA_W  read data; holds its last value between pulses.
rd_err_o  out  1  qualified by rd_valid_o; read address was >= DEPTH.

Behaviour:
- Reset, synchronous, active-high:
  - Read FSM goes to IDLE; wait counter = 0.
  - rd_valid_o = 0, rd_data_o = 0, rd_err_o = 0, rd_ready_o = 1 on the first cycle after reset.
  - Array contents are not reset; simulation initial block zero-fills.
  - While rst_i = 1, writes and read accepts are ignored.
- Write: on the edge where wr_en_i = 1 and wr_addr_i < DEPTH, each byte with wr_be_i[k] = 1 is updated; other bytes keep their old value. wr_addr_i >= DEPTH: write dropped silently. wr_be_i = 0: no change.
- Read accept: rd_req_i and rd_ready_o both high at an edge. The address is latched in that cycle.
- Read FSM states:
  - IDLE: rd_ready_o = 1. On accept, go to RESP if RD_LAT = 1, else go to WAIT with counter = RD_LAT-2.
  - WAIT: rd_ready_o = 0. Counter decrements each cycle; at 0, go to RESP.
  - RESP: rd_valid_o = 1 for exactly one cycle; rd_ready_o = 1. On accept, re-enter the WAIT/RESP sequence as from IDLE; otherwise go to IDLE.
- Latency: accept at edge N gives rd_valid_o high in cycle N+RD_LAT. Throughput:
  - RD_LAT = 1: one read per cycle.
  - Otherwise: one read per RD_LAT cycles.
- Array sampling: rd_data_o and rd_err_o are registered on the edge that enters RESP, using the latched address. The array value used is the one before any write committed on that same edge (read-first), unless RAM_FWD_EN is defined.
- Latched address >= DEPTH: rd_data_o = 0, rd_err_o = 1. Otherwise rd_err_o = 0.
- rd_req_i while rd_ready_o = 0: ignored. The requester must hold it; no queueing.
- Reset mid-read, i.e. in WAIT or RESP: the pending read is dropped and no rd_valid_o pulse is produced.
- Addresses are word addresses. No wrap-around: out-of-range never aliases onto a lower index.

Optional Feature:
Macro: RAM_FWD_EN.
- Defined: write-to-read forwarding. If a write to the latched read address commits on the same edge that samples the array, each byte with wr_be_i[k] = 1 takes wr_data_i; other bytes take the array value.
- Undefined: read-first. The old array word is returned, and the new data is visible to reads sampled on any later edge.
- Forwarding never applies to out-of-range addresses.

Test Plan:
1. Byte-strobe write (RD_LAT = 1): write 0xAABBCCDD to addr 5 with be = 4'hF, then 0x11223344 with be = 4'b0101, then read 5 -> rd_valid_o one cycle after accept, rd_data_o = 0xAA22CC44, rd_err_o = 0.
2. Wait states (RD_LAT = 4): accept a read of addr 3 at edge N -> rd_ready_o = 0 in cycles N+1..N+3, rd_valid_o high only in cycle N+4. rd_req_i held in cycles N+1..N+3 -> not accepted.
3. Back-to-back reads (RD_LAT = 1): rd_req_i held for addrs 0, 1, 2 on consecutive cycles -> three consecutive rd_valid_o pulses, data in order, rd_ready_o constantly 1.
4. Out of range (DEPTH = 1024): write 0xDEADBEEF to addr 1024, then read addr 1024 -> rd_data_o = 0, rd_err_o = 1. Read addr 0 -> unchanged, rd_err_o = 0.
5. Collision: addr 7 holds 0x00000000. Write 0x12345678 with be = 4'b0011 to addr 7 on the edge entering RESP for a read of addr 7 -> with RAM_FWD_EN, rd_data_o = 0x00005678; without it, 0x00000000. The next read of addr 7 returns 0x00005678 in both builds.
6. Reset mid-read (RD_LAT = 3): assert rst_i one cycle after accept -> no rd_valid_o pulse, rd_data_o = 0, rd_ready_o = 1 after rst_i falls, previously written array data still readable.
